// File: rtl/bcd_page_scroller.sv
// bcd_page_scroller: pages a wide BCD snapshot across a narrow bank of
// 7-segment digits, most-significant page first, with an optional blank
// separator page, double-buffered snapshots and leading-zero blanking.
module bcd_page_scroller #(
  parameter int         NUM_DIGITS  = 9,
  parameter int         DISP_DIGITS = 3,
  parameter int         PRESCALE    = 25000000,
  parameter int         BLANK_PAGE  = 1,
  parameter logic [3:0] BLANK_CODE  = 4'hF,
  parameter int         LZ_SUPPRESS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     step,
  input  logic                     load,
  input  logic [4*NUM_DIGITS-1:0]  digits_in,
  output logic [4*DISP_DIGITS-1:0] disp_out,
  output logic [3:0]               page_idx,
  output logic                     frame_start,
  output logic                     valid
);

  localparam int NPAGES     = (NUM_DIGITS + DISP_DIGITS - 1) / DISP_DIGITS;
  localparam int PAD_DIGITS = NPAGES * DISP_DIGITS;
  localparam int LAST_PAGE  = NPAGES - 1 + BLANK_PAGE;
  localparam int CNT_W      = $clog2(PRESCALE);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        pcnt;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_p0;
  logic [4*NUM_DIGITS-1:0] active_p1;

  logic                    start;
  logic                    tick;
  logic                    adv;
  logic                    wrap;
  logic [3:0]              next_page;
  logic [4*NUM_DIGITS-1:0] next_active;

  // Blank zeros from the top digit downward; digit 0 always stays visible.
  function automatic logic [4*NUM_DIGITS-1:0] lz_blank(input logic [4*NUM_DIGITS-1:0] d);
    logic [4*NUM_DIGITS-1:0] r;
    logic                    lead;
    r    = d;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) r[4*i +: 4] = BLANK_CODE;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  // Select the digits of one page from a buffer padded on top with blanks.
  function automatic logic [4*DISP_DIGITS-1:0] page_view(input logic [3:0] pg,
                                                         input logic [4*NUM_DIGITS-1:0] src);
    logic [4*PAD_DIGITS-1:0] padded;
    int                      k;
    padded                   = {PAD_DIGITS{BLANK_CODE}};
    padded[4*NUM_DIGITS-1:0] = src;
    k                        = int'(pg) - BLANK_PAGE;
    if (k < 0) return {DISP_DIGITS{BLANK_CODE}};
    return padded[(NPAGES - 1 - k) * 4 * DISP_DIGITS +: 4 * DISP_DIGITS];
  endfunction

  // Advance decisions: start out of IDLE, prescaler tick, page advance, frame wrap.
  always_comb begin
    start       = (state == ST_IDLE) && pending;
    tick        = (state == ST_RUN) && en && (pcnt == CNT_W'(PRESCALE - 1));
    adv         = (state == ST_RUN) && (tick || step);
    wrap        = adv && (page_idx == 4'(LAST_PAGE));
    next_page   = wrap ? 4'd0 : page_idx + 4'd1;
    next_active = (start || (wrap && pending)) ? shadow_p0 : active_p1;
  end

  // Control state: FSM, prescaler, page index, pending snapshot, pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pcnt        <= '0;
      pending     <= 1'b0;
      page_idx    <= 4'd0;
      frame_start <= 1'b0;
      valid       <= 1'b0;
    end else begin
      frame_start <= start || wrap;
      pending     <= load || (pending && !(start || wrap));
      if (start) begin
        state    <= ST_RUN;
        valid    <= 1'b1;
        page_idx <= 4'd0;
        pcnt     <= '0;
      end else begin
        if (adv) page_idx <= next_page;
        if (state == ST_RUN) begin
          if (step || tick) pcnt <= '0;
          else if (en)      pcnt <= pcnt + CNT_W'(1);
        end
      end
    end
  end

  // Snapshot buffers and registered display; shadow_p0 -> active_p1 -> disp_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_p0 <= {NUM_DIGITS{BLANK_CODE}};
      active_p1 <= {NUM_DIGITS{BLANK_CODE}};
      disp_out  <= {DISP_DIGITS{BLANK_CODE}};
    end else begin
      if (load) shadow_p0 <= (LZ_SUPPRESS != 0) ? lz_blank(digits_in) : digits_in;
      active_p1 <= next_active;
      if (start || adv) disp_out <= page_view(start ? 4'd0 : next_page, next_active);
    end
  end

endmodule
